// File: rtl/star_scanner.sv
// Raster scanner over the galaxy frame memory: finds the next bright pixel that
// lies outside every recorded star box and reports its coordinates once.
module star_scanner #(
    parameter int               xSz       = 8,
    parameter int               ySz       = 7,
    parameter int               colSz     = 3,
    parameter int               X_MAX     = 160,
    parameter int               Y_MAX     = 120,
    parameter logic [colSz-1:0] THRESH    = colSz'(7),
    parameter int               MAX_BOXES = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             goScan,
    input  logic             rewind,
    input  logic             ackFound,
    input  logic             boxAdd,
    input  logic             clearBoxes,
    input  logic [xSz-1:0]   xLeft,
    input  logic [xSz-1:0]   xRight,
    input  logic [ySz-1:0]   yTop,
    input  logic [ySz-1:0]   yBottom,
    output logic [14:0]      mem_addr,
    input  logic [colSz-1:0] mem_data,
    output logic [xSz-1:0]   xCount,
    output logic [ySz-1:0]   yCount,
    output logic             starFound,
    output logic             scanDone,
    output logic             busy
);

    localparam int PW = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_FOUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state;
    logic [xSz-1:0]       x_pos, x_next;
    logic [ySz-1:0]       y_pos, y_next;
    logic                 last_px, excluded, hit;

    logic [MAX_BOXES-1:0] bx_valid;
    logic [PW-1:0]        wptr;
    logic [xSz-1:0]       bx_xl [MAX_BOXES];
    logic [xSz-1:0]       bx_xr [MAX_BOXES];
    logic [ySz-1:0]       bx_yt [MAX_BOXES];
    logic [ySz-1:0]       bx_yb [MAX_BOXES];

    assign mem_addr  = 15'(y_pos) * 15'(X_MAX) + 15'(x_pos);
    assign starFound = (state == S_FOUND);
    assign scanDone  = (state == S_DONE);
    assign busy      = (state == S_FETCH) || (state == S_CHECK);

    always_comb begin
        last_px = (x_pos == xSz'(X_MAX - 1)) && (y_pos == ySz'(Y_MAX - 1));
        if (x_pos == xSz'(X_MAX - 1)) begin
            x_next = '0;
            y_next = y_pos + ySz'(1);
        end else begin
            x_next = x_pos + xSz'(1);
            y_next = y_pos;
        end
    end

    // Inverted boxes (left>right or top>bottom) fail the range test on their own.
    always_comb begin
        excluded = 1'b0;
        for (int unsigned i = 0; i < MAX_BOXES; i++) begin
            if (bx_valid[PW'(i)] &&
                (bx_xl[PW'(i)] <= x_pos) && (x_pos <= bx_xr[PW'(i)]) &&
                (bx_yt[PW'(i)] <= y_pos) && (y_pos <= bx_yb[PW'(i)]))
                excluded = 1'b1;
        end
        hit = (mem_data >= THRESH) && !excluded;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bx_valid <= '0;
            wptr     <= '0;
            for (int unsigned i = 0; i < MAX_BOXES; i++) begin
                bx_xl[PW'(i)] <= '0;
                bx_xr[PW'(i)] <= '0;
                bx_yt[PW'(i)] <= '0;
                bx_yb[PW'(i)] <= '0;
            end
        end else if (clearBoxes) begin
            bx_valid <= '0;
            wptr     <= '0;
        end else if (boxAdd) begin
            bx_xl[wptr]    <= xLeft;
            bx_xr[wptr]    <= xRight;
            bx_yt[wptr]    <= yTop;
            bx_yb[wptr]    <= yBottom;
            bx_valid[wptr] <= 1'b1;
            wptr <= (wptr == PW'(MAX_BOXES - 1)) ? '0 : wptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            x_pos  <= '0;
            y_pos  <= '0;
            xCount <= '0;
            yCount <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rewind) begin
                        x_pos <= '0;
                        y_pos <= '0;
                    end else if (goScan) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_CHECK;
                S_CHECK: begin
                    if (hit) begin
                        state  <= S_FOUND;
                        xCount <= x_pos;
                        yCount <= y_pos;
                    end else if (last_px) begin
                        state <= S_DONE;
                    end else begin
                        x_pos <= x_next;
                        y_pos <= y_next;
                        state <= S_FETCH;
                    end
                end
                S_FOUND: begin
                    if (ackFound) begin
                        if (last_px) begin
                            state <= S_DONE;
                        end else begin
                            x_pos <= x_next;
                            y_pos <= y_next;
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (rewind) begin
                        x_pos <= '0;
                        y_pos <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_scanner.sv
// Directed bench for star_scanner with a registered frame ROM model and an
// expected-event scoreboard checked against starFound/scanDone and their latency.
module tb_star_scanner;

    logic        clk = 1'b0;
    logic        resetn;
    logic        goScan, rewind, ackFound, boxAdd, clearBoxes;
    logic [7:0]  xLeft, xRight;
    logic [6:0]  yTop, yBottom;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic [7:0]  xCount;
    logic [6:0]  yCount;
    logic        starFound, scanDone, busy;

    logic [2:0]  frame [0:19199];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        bit done;
        int x;
        int y;
        int lat;
    } exp_t;
    exp_t sb[$];

    star_scanner dut (
        .clk(clk), .resetn(resetn), .goScan(goScan), .rewind(rewind),
        .ackFound(ackFound), .boxAdd(boxAdd), .clearBoxes(clearBoxes),
        .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
        .mem_addr(mem_addr), .mem_data(mem_data), .xCount(xCount), .yCount(yCount),
        .starFound(starFound), .scanDone(scanDone), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_data <= frame[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int p0, input int p);
        return 2 * (p - p0) + 2;
    endfunction

    task automatic pulse_go(output int k);
        @(negedge clk);
        goScan = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        @(negedge clk);
        goScan = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ackFound = 1'b1;
        @(negedge clk);
        ackFound = 1'b0;
    endtask

    task automatic do_rewind();
        @(negedge clk);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
    endtask

    task automatic add_box(input int xl, input int xr, input int yt, input int yb);
        @(negedge clk);
        xLeft = 8'(xl); xRight = 8'(xr); yTop = 7'(yt); yBottom = 7'(yb);
        boxAdd = 1'b1;
        @(negedge clk);
        boxAdd = 1'b0;
    endtask

    // Push the expected outcome, start the scan, then pop and compare on the first output event.
    task automatic run_scan(input bit done, input int ex, input int ey, input int lat, input int budget);
        int  k;
        int  ev;
        bit  got;
        exp_t e;
        sb.push_back('{done: done, x: ex, y: ey, lat: lat});
        pulse_go(k);
        got = 1'b0;
        ev  = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (starFound || scanDone) begin
                got = 1'b1;
                ev  = cyc;
                break;
            end
        end
        e = sb.pop_front();
        check("event_seen", 32'(got), 32'd1);
        if (got) begin
            check("scanDone", 32'(scanDone), 32'(e.done));
            check("starFound", 32'(starFound), 32'(!e.done));
            check("latency", 32'(ev - k), 32'(e.lat));
            if (!e.done) begin
                check("xCount", 32'(xCount), 32'(e.x));
                check("yCount", 32'(yCount), 32'(e.y));
            end
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 19200; i++) frame[i] = 3'd0;
        resetn = 1'b0; goScan = 1'b0; rewind = 1'b0; ackFound = 1'b0;
        boxAdd = 1'b0; clearBoxes = 1'b0;
        xLeft = '0; xRight = '0; yTop = '0; yBottom = '0;

        // Reset state, then idle without goScan
        repeat (2) @(posedge clk);
        #1;
        check("rst_starFound", 32'(starFound), 32'd0);
        check("rst_scanDone", 32'(scanDone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_xCount", 32'(xCount), 32'd0);
        check("rst_yCount", 32'(yCount), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_starFound", 32'(starFound), 32'd0);
        check("idle_mem_addr", 32'(mem_addr), 32'd0);

        // Single star at (5,2)
        frame[2*160 + 5] = 3'd7;
        run_scan(1'b0, 5, 2, lat_of(0, 325), 1000);

        // Hold without ack; rewind and goScan are ignored while FOUND
        @(negedge clk);
        rewind = 1'b1; goScan = 1'b1;
        @(negedge clk);
        rewind = 1'b0; goScan = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("hold_starFound", 32'(starFound), 32'd1);
            check("hold_xCount", 32'(xCount), 32'd5);
            check("hold_yCount", 32'(yCount), 32'd2);
        end
        @(negedge clk);
        ackFound = 1'b1;
        @(posedge clk);
        #1;
        check("ack_starFound", 32'(starFound), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_resume_addr", 32'(mem_addr), 32'(2*160 + 6));
        @(negedge clk);
        ackFound = 1'b0;

        // Resume from (6,2): next star two pixels further on
        frame[2*160 + 8] = 3'd7;
        run_scan(1'b0, 8, 2, lat_of(326, 328), 100);
        do_ack();
        frame[2*160 + 8] = 3'd0;

        // Box over (5,2); rewind; only (150,119) reported, then frame runs out
        frame[119*160 + 150] = 3'd7;
        add_box(4, 6, 1, 3);
        do_rewind();
        #1;
        check("rewind_addr", 32'(mem_addr), 32'd0);
        run_scan(1'b0, 150, 119, lat_of(0, 19190), 40000);
        do_ack();
        run_scan(1'b1, 0, 0, lat_of(19191, 19199), 100);
        @(negedge clk);
        goScan = 1'b1;
        @(negedge clk);
        goScan = 1'b0;
        #1;
        check("done_ignores_go", 32'(scanDone), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        do_rewind();
        #1;
        check("done_rewind_clear", 32'(scanDone), 32'd0);
        check("done_rewind_addr", 32'(mem_addr), 32'd0);

        // Nine boxes after a clear: first one (over (5,2)) gets overwritten
        @(negedge clk);
        clearBoxes = 1'b1;
        @(negedge clk);
        clearBoxes = 1'b0;
        add_box(5, 5, 2, 2);
        add_box(10, 0, 0, 119);
        for (int i = 0; i < 7; i++) add_box(20 + i, 30 + i, 10, 20);
        do_rewind();
        run_scan(1'b0, 5, 2, lat_of(0, 325), 1000);
        do_ack();

        // Empty frame, full sweep to DONE
        frame[2*160 + 5]    = 3'd0;
        frame[119*160 + 150] = 3'd0;
        do_rewind();
        run_scan(1'b1, 0, 0, lat_of(0, 19199), 40000);

        // Reset mid-scan aborts everything
        do_rewind();
        pulse_go(k);
        repeat (50) @(posedge clk);
        #1;
        check("midscan_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_starFound", 32'(starFound), 32'd0);
        check("abort_scanDone", 32'(scanDone), 32'd0);
        check("abort_xCount", 32'(xCount), 32'd0);
        check("abort_yCount", 32'(yCount), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
